// File: rtl/pdm_pkg.sv
// Shared playback constants and the playback state encoding.
// Word layout: SAMPLES_PER_WORD samples of SAMPLE_W bits, first-played sample in the MSBs.
package pdm_pkg;
    localparam int SAMPLE_W         = 8;
    localparam int SAMPLES_PER_WORD = 4;
    localparam int CHUNKS           = 2830;
    localparam int SAMPLE_FREQ      = 10000;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} pb_state_t;
endpackage

// File: rtl/sigma_delta_mod.sv
// sigma_delta_mod: first-order sigma-delta modulator, one step per tick.
// Latency: bit_out updates on the tick edge. Backpressure: none, tick-driven.
// clr zeroes the accumulator and the registered carry output.
module sigma_delta_mod #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                tick,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                bit_out
);
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, sample};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc     <= '0;
            bit_out <= 1'b0;
        end else if (tick) begin
            acc     <= sum[SAMPLE_W-1:0];
            bit_out <= sum[SAMPLE_W];
        end
    end
endmodule

// File: rtl/pdm_playback.sv
// pdm_playback: plays packed RAM words (4 samples each) out as a 1-bit PDM stream.
// Latency: start at T -> ram_rd at T+1, PLAY/pdm_sd at T+3, first PDM bit at T+4.
// Backpressure: none; RAM returns data one cycle after ram_rd. PDM_PB_LOOP_EN adds looped playback.
module pdm_playback #(
    parameter int SAMPLE_W        = pdm_pkg::SAMPLE_W,
    parameter int CLKS_PER_BIT    = 2,
    parameter int BITS_PER_SAMPLE = 240,
    parameter int DEPTH           = pdm_pkg::CHUNKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
`ifdef PDM_PB_LOOP_EN
    input  logic                  loop,
`endif
    input  logic [11:0]           num_words,
    input  logic [4*SAMPLE_W-1:0] ram_rd_data,
    output logic                  ram_rd,
    output logic [11:0]           ram_addr,
    output logic                  pdm_out,
    output logic                  pdm_sd,
    output logic                  busy,
    output logic                  done
);
    import pdm_pkg::*;

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (BITS_PER_SAMPLE > 1) ? $clog2(BITS_PER_SAMPLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_SAMPLE - 1);
    localparam logic [11:0]      DEPTH_W  = 12'(DEPTH);

    pb_state_t state, state_nxt;

    logic [DIV_W-1:0]                     div_cnt;
    logic [BIT_W-1:0]                     bit_cnt;
    logic [1:0]                           samp_idx;
    logic [11:0]                          word_idx;
    logic [11:0]                          len;
    logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] cur_word;
    logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] nxt_word;
    logic                                 pf_pend;
    logic [SAMPLE_W-1:0]                  sample;
    logic start_ok, tick, period_end, sample_end, word_end;
    logic last_word, pass_end, prefetch, sdm_bit;

`ifdef PDM_PB_LOOP_EN
    logic loop_q;
    always_ff @(posedge clk) begin
        if (rst)
            loop_q <= 1'b0;
        else if (start_ok)
            loop_q <= loop;
    end
`else
    logic loop_q;
    assign loop_q = 1'b0;
`endif

    assign start_ok   = (state == IDLE) && start && !stop;
    assign tick       = (state == PLAY) && (div_cnt == '0);
    assign period_end = (state == PLAY) && (div_cnt == DIV_LAST);
    assign sample_end = period_end && (bit_cnt == BIT_LAST);
    assign word_end   = sample_end && (samp_idx == 2'd3);
    assign last_word  = (word_idx == len - 12'd1);
    assign pass_end   = word_end && last_word;
    // Registered read strobe: raise it on the last edge of sample 2 so it is seen in sample 3's first cycle.
    assign prefetch   = sample_end && (samp_idx == 2'd2) && (!last_word || loop_q);

    always_comb begin
        case (samp_idx)
            2'd0:    sample = cur_word[3*SAMPLE_W +: SAMPLE_W];
            2'd1:    sample = cur_word[2*SAMPLE_W +: SAMPLE_W];
            2'd2:    sample = cur_word[1*SAMPLE_W +: SAMPLE_W];
            default: sample = cur_word[0 +: SAMPLE_W];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok && (num_words != 12'd0)) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = PLAY;
            PLAY:    if (pass_end && !loop_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (stop)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            samp_idx <= '0;
            word_idx <= '0;
            len      <= '0;
            cur_word <= '0;
            nxt_word <= '0;
            pf_pend  <= 1'b0;
            ram_rd   <= 1'b0;
            ram_addr <= '0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            ram_rd  <= 1'b0;
            pf_pend <= ram_rd && (state == PLAY);
            if (pf_pend)
                nxt_word <= ram_rd_data;
            if (start_ok) begin
                if (num_words == 12'd0) begin
                    done <= 1'b1;
                end else begin
                    len      <= (num_words > DEPTH_W) ? DEPTH_W : num_words;
                    word_idx <= '0;
                    samp_idx <= '0;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    ram_rd   <= 1'b1;
                    ram_addr <= '0;
                end
            end else if (!stop) begin
                if (state == WAIT)
                    cur_word <= ram_rd_data;
                if (state == PLAY) begin
                    div_cnt <= period_end ? '0 : div_cnt + DIV_W'(1);
                    if (sample_end) begin
                        bit_cnt  <= '0;
                        samp_idx <= samp_idx + 2'd1;
                    end else if (period_end) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    if (word_end) begin
                        cur_word <= nxt_word;
                        word_idx <= last_word ? 12'd0 : word_idx + 12'd1;
                        done     <= last_word;
                    end
                    if (prefetch) begin
                        ram_rd   <= 1'b1;
                        ram_addr <= last_word ? 12'd0 : word_idx + 12'd1;
                    end
                end
            end
        end
    end

    sigma_delta_mod #(.SAMPLE_W(SAMPLE_W)) u_sdm (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .tick    (tick),
        .sample  (sample),
        .bit_out (sdm_bit)
    );

    assign pdm_out = sdm_bit && (state == PLAY);
    assign pdm_sd  = (state == PLAY);
    assign busy    = (state != IDLE);
endmodule

// File: tb/tb_pdm_playback.sv
// Bench for pdm_playback with CLKS_PER_BIT=2, BITS_PER_SAMPLE=4 and a small DEPTH.
// A behavioural RAM and a schedule-based reference model give the expected outputs per cycle.
module tb_pdm_playback;
    localparam int CPB      = 2;
    localparam int BPS      = 4;
    localparam int DEP      = 6;
    localparam int WORD_CYC = 4 * BPS * CPB;
    localparam int PF_OFF   = 3 * BPS * CPB;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [11:0] num_words;
    logic [31:0] ram_rd_data;
    logic        ram_rd;
    logic [11:0] ram_addr;
    logic        pdm_out, pdm_sd, busy, done;
`ifdef PDM_PB_LOOP_EN
    logic        loop;
`endif

    logic [31:0] mem [0:4095];
    bit          pdm_ref [0:4095];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_rd) ram_rd_data <= mem[ram_addr];

    pdm_playback #(
        .SAMPLE_W(8), .CLKS_PER_BIT(CPB), .BITS_PER_SAMPLE(BPS), .DEPTH(DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
`ifdef PDM_PB_LOOP_EN
        .loop        (loop),
`endif
        .num_words   (num_words),
        .ram_rd_data (ram_rd_data),
        .ram_rd      (ram_rd),
        .ram_addr    (ram_addr),
        .pdm_out     (pdm_out),
        .pdm_sd      (pdm_sd),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int nw;
        int stop_k;
        int start2_k;
        bit fixed;
        int exp_reads;
        int exp_dones;
        int exp_last;
    } case_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [16:0] out_vec();
        return {ram_rd, ram_rd ? ram_addr : 12'd0, pdm_out, pdm_sd, busy, done};
    endfunction

    // Reference bitstream: sample sequence of the clip (wrapping for loops), carry of a running mod-256 sum.
    task automatic build_ref(input int len);
        int acc, w, s, smp;
        acc = 0;
        for (int n = 0; n < 4096; n++) begin
            if (len == 0) begin
                pdm_ref[n] = 1'b0;
            end else begin
                w   = (n / (4 * BPS)) % len;
                s   = (n / BPS) % 4;
                smp = int'((mem[w] >> (24 - 8 * s)) & 32'hFF);
                acc = acc + smp;
                pdm_ref[n] = (acc >= 256);
                acc = acc % 256;
            end
        end
    endtask

    // Expected {ram_rd, addr, pdm_out, pdm_sd, busy, done} k cycles after the start cycle.
    function automatic logic [16:0] exp_vec(input int k, input int len, input int stop_k, input bit lp);
        logic        rd, o, sd, b, d;
        logic [11:0] a;
        int          p;
        rd = 1'b0; o = 1'b0; sd = 1'b0; b = 1'b0; d = 1'b0; a = 12'd0;
        if (stop_k > 0 && k > stop_k) return '0;
        if (len == 0) return {16'd0, k == 1};
        if (!lp && k > 3 + WORD_CYC * len) return '0;
        if (!lp && k == 3 + WORD_CYC * len) return 17'd1;
        b = 1'b1;
        if (k == 1) begin
            rd = 1'b1;
        end else if (k >= 3) begin
            p  = k - 3;
            sd = 1'b1;
            if (p > 0) o = pdm_ref[(p - 1) / CPB];
            if ((p % WORD_CYC == PF_OFF) && (lp || (p / WORD_CYC + 1 < len))) begin
                rd = 1'b1;
                a  = 12'((p / WORD_CYC + 1) % len);
            end
            if (p > 0 && (p % (WORD_CYC * len) == 0)) d = 1'b1;
        end
        return {rd, a, o, sd, b, d};
    endfunction

    task automatic run_case(input int nw, input int stop_k, input int start2_k, input bit lp,
                            input int max_k, output int reads, output int dones, output int last_addr);
        int len;
        len = (nw > DEP) ? DEP : nw;
        build_ref(len);
        reads = 0; dones = 0; last_addr = -1;
        num_words = 12'(nw);
        start     = 1'b1;
`ifdef PDM_PB_LOOP_EN
        loop      = lp;
`endif
        step();
        start = 1'b0;
        for (int k = 1; k <= max_k; k++) begin
            check($sformatf("nw%0d_cyc%0d", nw, k), 32'(out_vec()), 32'(exp_vec(k, len, stop_k, lp)));
            if (ram_rd) begin
                reads++;
                last_addr = int'(ram_addr);
            end
            if (done) dones++;
            if (k == stop_k) stop = 1'b1;
            if (k == start2_k) begin
                start     = 1'b1;
                num_words = 12'd1;
            end
            step();
            stop  = 1'b0;
            start = 1'b0;
        end
    endtask

    case_t tbl [8];
    int    reads, dones, last_addr, len_i, max_k, nw;

    initial begin
        tbl[0] = '{1,    0,  0,  1'b1, 1, 1, 0};
        tbl[1] = '{3,    0,  0,  1'b0, 3, 1, 2};
        tbl[2] = '{0,    0,  0,  1'b0, 0, 1, -1};
        tbl[3] = '{4000, 0,  0,  1'b0, 6, 1, 5};
        tbl[4] = '{3,    45, 0,  1'b0, 2, 0, 1};
        tbl[5] = '{2,    0,  20, 1'b0, 2, 1, 1};
        tbl[6] = '{5,    0,  0,  1'b0, 5, 1, 4};
        tbl[7] = '{6,    0,  0,  1'b0, 6, 1, 5};

        rst = 1'b1; start = 1'b0; stop = 1'b0; num_words = 12'd0; ram_rd_data = 32'd0;
`ifdef PDM_PB_LOOP_EN
        loop = 1'b0;
`endif
        for (int a = 0; a < 4096; a++) mem[a] = 32'd0;
        step(); step();
        check("reset_outputs", 32'(out_vec()), 32'd0);
        rst = 1'b0;
        step();
        check("idle_after_reset", 32'(out_vec()), 32'd0);

        for (int i = 0; i < 8; i++) begin
            for (int a = 0; a < DEP; a++) mem[a] = $urandom;
            if (tbl[i].fixed) mem[0] = 32'hFF00_80FF;
            len_i = (tbl[i].nw > DEP) ? DEP : tbl[i].nw;
            max_k = (tbl[i].stop_k > 0) ? tbl[i].stop_k + 3 : 3 + WORD_CYC * len_i + 2;
            run_case(tbl[i].nw, tbl[i].stop_k, tbl[i].start2_k, 1'b0, max_k, reads, dones, last_addr);
            check($sformatf("row%0d_reads", i), 32'(reads), 32'(tbl[i].exp_reads));
            check($sformatf("row%0d_dones", i), 32'(dones), 32'(tbl[i].exp_dones));
            check($sformatf("row%0d_last_addr", i), 32'(last_addr), 32'(tbl[i].exp_last));
            step(); step();
        end

        for (int i = 0; i < 4; i++) begin
            for (int a = 0; a < DEP; a++) mem[a] = $urandom;
            nw    = int'($urandom_range(1, DEP + 2));
            len_i = (nw > DEP) ? DEP : nw;
            run_case(nw, 0, 0, 1'b0, 3 + WORD_CYC * len_i + 2, reads, dones, last_addr);
            check($sformatf("rand%0d_reads", i), 32'(reads), 32'(len_i));
            check($sformatf("rand%0d_last_addr", i), 32'(last_addr), 32'(len_i - 1));
            check($sformatf("rand%0d_dones", i), 32'(dones), 32'd1);
        end

        // stop and start in the same idle cycle: nothing may happen
        stop = 1'b1; start = 1'b1; num_words = 12'd3;
        step();
        stop = 1'b0; start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stop_start_idle%0d", k), 32'(out_vec()), 32'd0);
            step();
        end

        // synchronous reset in the middle of playback
        num_words = 12'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40; k++) step();
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("rst_midplay", 32'(out_vec()), 32'd0);
        rst = 1'b0;
        step(); step();
        check("rst_midplay_idle", 32'(out_vec()), 32'd0);

`ifdef PDM_PB_LOOP_EN
        for (int a = 0; a < DEP; a++) mem[a] = $urandom;
        run_case(2, 200, 0, 1'b1, 203, reads, dones, last_addr);
        check("loop_reads", 32'(reads), 32'd7);
        check("loop_dones", 32'(dones), 32'd3);
        check("loop_last_addr", 32'(last_addr), 32'd0);
        loop = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
